// File: rtl/lsu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_pkg
//  Description : Shared types and helpers for the load/store memory bridge:
//                access-size and FSM-state encodings, and byte-lane helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_mem_pkg;

    // Access width as carried on req_size
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    // Bridge transaction phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } bridge_state_e;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input mem_size_e size);
        return 4'd1 << size;
    endfunction

    // Bit mask covering the bytes of an access, placed at its byte lane.
    // A doubleword covers the full word; shifting 1 by 64 is avoided.
    function automatic logic [63:0] byte_mask_bits(input mem_size_e size,
                                                   input logic [2:0] off);
        logic [63:0] base;
        if (size == SIZE_D) begin
            base = {64{1'b1}};
        end else begin
            base = (64'd1 << {size_bytes(size), 3'b000}) - 64'd1;
        end
        return base << {off, 3'b000};
    endfunction

endpackage : lsu_mem_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Combinational load-data aligner. Moves the addressed lane of
//                a 64-bit memory word down to bit 0, truncates it to the
//                access width and sign- or zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_mem_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  off,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [63:0] rdata
);

    logic [63:0] w_shifted;

    assign w_shifted = raw >> {off, 3'b000};

    // Truncate to the access width and extend back to 64 bits
    always_comb begin
        rdata = w_shifted;
        case (size)
            SIZE_B: rdata = {{56{sign_ext & w_shifted[7]}},  w_shifted[7:0]};
            SIZE_H: rdata = {{48{sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            SIZE_W: rdata = {{32{sign_ext & w_shifted[31]}}, w_shifted[31:0]};
            default: rdata = w_shifted;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_bridge
//  Description : Single-outstanding load/store bridge from the core request
//                channel to a word-indexed simulation memory port. Converts
//                byte addresses to word index + lane data/mask, aligns load
//                data, flags misaligned and below-base accesses without
//                touching memory, and returns a response on a handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge
    import lsu_mem_pkg::*;
#(
    parameter logic [63:0] MEM_BASE = 64'h8000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    // response channel
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    // memory port
    output logic        mem_r_enable,
    output logic [63:0] mem_r_index,
    input  logic [63:0] mem_r_data,
    output logic        mem_w_enable,
    output logic [63:0] mem_w_index,
    output logic [63:0] mem_w_data,
    output logic [63:0] mem_w_mask
);

    bridge_state_e r_state;
    bridge_state_e w_state_next;

    // accept-cycle decode
    logic        w_accept;
    logic        w_misaligned;
    logic        w_below;
    logic        w_err;
    logic [63:0] w_index;
    logic [5:0]  w_shamt;
    mem_size_e   w_size;

    // captured transaction
    logic        r_wen;
    mem_size_e   r_size;
    logic [2:0]  r_off;
    logic        r_signed;
    logic [63:0] r_rdata;
    logic        r_err;

    // registered memory port, live only during ISSUE
    logic        r_mem_r_enable;
    logic [63:0] r_mem_r_index;
    logic        r_mem_w_enable;
    logic [63:0] r_mem_w_index;
    logic [63:0] r_mem_w_data;
    logic [63:0] r_mem_w_mask;

    logic [63:0] w_load_aligned;

    assign w_accept = req_valid && req_ready;
    assign w_size   = mem_size_e'(req_size);
    assign w_below  = req_addr < MEM_BASE;
    assign w_err    = w_misaligned || w_below;
    assign w_index  = (req_addr - MEM_BASE) >> 3;
    assign w_shamt  = {req_addr[2:0], 3'b000};

    // Natural-alignment test: the low log2(size) address bits must be zero
    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            SIZE_H:  w_misaligned = req_addr[0];
            SIZE_W:  w_misaligned = |req_addr[1:0];
            SIZE_D:  w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: errors skip memory, stores skip the data-return phase
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_next = r_wen ? ST_RESP : ST_RDATA;
            ST_RDATA: w_state_next = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs; the memory port is forced quiet while reset is asserted so an
    // in-flight strobe is dropped at the very edge reset is sampled
    always_comb begin
        req_ready    = (r_state == ST_IDLE);
        resp_valid   = (r_state == ST_RESP);
        resp_rdata   = r_rdata;
        resp_err     = r_err;
        mem_r_enable = r_mem_r_enable & rst_n;
        mem_r_index  = rst_n ? r_mem_r_index : 64'd0;
        mem_w_enable = r_mem_w_enable & rst_n;
        mem_w_index  = rst_n ? r_mem_w_index : 64'd0;
        mem_w_data   = rst_n ? r_mem_w_data  : 64'd0;
        mem_w_mask   = rst_n ? r_mem_w_mask  : 64'd0;
    end

    // Capture the request, collect aligned load data, clear on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen    <= 1'b0;
            r_size   <= SIZE_B;
            r_off    <= 3'd0;
            r_signed <= 1'b0;
            r_rdata  <= 64'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wen    <= req_wen;
                r_size   <= w_size;
                r_off    <= req_addr[2:0];
                r_signed <= req_signed;
                r_rdata  <= 64'd0;
                r_err    <= w_err;
            end else if (r_state == ST_RDATA) begin
                r_rdata  <= w_load_aligned;
            end else if (r_state == ST_RESP && resp_ready) begin
                r_rdata  <= 64'd0;
                r_err    <= 1'b0;
            end
        end
    end

    // Memory port registers: loaded only on an error-free accept so they are
    // valid exactly for the single ISSUE cycle and zero everywhere else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_r_enable <= 1'b0;
            r_mem_r_index  <= 64'd0;
            r_mem_w_enable <= 1'b0;
            r_mem_w_index  <= 64'd0;
            r_mem_w_data   <= 64'd0;
            r_mem_w_mask   <= 64'd0;
        end else if (w_accept && !w_err) begin
            r_mem_r_enable <= !req_wen;
            r_mem_r_index  <= req_wen ? 64'd0 : w_index;
            r_mem_w_enable <= req_wen;
            r_mem_w_index  <= req_wen ? w_index : 64'd0;
            r_mem_w_data   <= req_wen ? (req_wdata << w_shamt) : 64'd0;
            r_mem_w_mask   <= req_wen ? byte_mask_bits(w_size, req_addr[2:0]) : 64'd0;
        end else begin
            r_mem_r_enable <= 1'b0;
            r_mem_r_index  <= 64'd0;
            r_mem_w_enable <= 1'b0;
            r_mem_w_index  <= 64'd0;
            r_mem_w_data   <= 64'd0;
            r_mem_w_mask   <= 64'd0;
        end
    end

    lsu_load_align u_load_align (
        .raw      (mem_r_data),
        .off      (r_off),
        .size     (r_size),
        .sign_ext (r_signed),
        .rdata    (w_load_aligned)
    );

endmodule : lsu_mem_bridge
`default_nettype wire

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Load/store bridge between the core's memory-request channel and the `MemRWHelper` simulation memory in `top`. It accepts one byte-addressed load or store at a time over a valid/ready handshake and converts it to a 64-bit word index with lane-shifted data and a bit mask. It issues a single `MemRWHelper` access, aligns and sign- or zero-extends load data, and returns a response over a second valid/ready handshake. Misaligned and out-of-range requests never reach the memory port.

## Interface
- `MEM_BASE`, default `64'h8000_0000`: byte address that maps to memory word index 0.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid` / `req_ready`  in / out  1 / 1  request handshake.
- `req_addr`  in  64  byte address.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = B, 1 = H, 2 = W, 3 = D.
- `req_signed`  in  1  sign-extend load data; ignored for stores.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid` / `resp_ready`  out / in  1 / 1  response handshake.
- `resp_rdata`  out  64  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or below-`MEM_BASE` access.
- `mem_r_enable`  out  1  `MemRWHelper` read strobe.
- `mem_r_index`  out  64  read word index.
- `mem_r_data`  in  64  read data, valid the cycle after `mem_r_enable` is sampled.
- `mem_w_enable`  out  1  write strobe.
- `mem_w_index`  out  64  write word index.
- `mem_w_data`  out  64  lane-shifted write data.
- `mem_w_mask`  out  64  bit mask; each enabled byte contributes 8 ones.

## Operation
- The FSM has four states: IDLE, ISSUE, RDATA, RESP.
- `req_ready` = (state == IDLE). A request is accepted on a cycle with `req_valid && req_ready`.
- On accept, the bridge registers addr, wen, size, signed and wdata, and computes:
  - `off = addr[2:0]`
  - `index = (addr - MEM_BASE) >> 3`
  - `err = misaligned || addr < MEM_BASE`
  - misaligned means `addr[size-1:0] != 0` for size > 0.
- Transitions out of IDLE on accept: `err` → RESP; otherwise → ISSUE.
- ISSUE:
  - Exactly one memory strobe is asserted. Loads drive `mem_r_enable`=1 with `mem_r_index`=index. Stores drive `mem_w_enable`=1, `mem_w_index`=index, `mem_w_data = wdata << (8*off)`, `mem_w_mask = ((1 << (8 << size)) - 1) << (8*off)`. For size 3 the mask is all ones.
  - Load → RDATA. Store → RESP.
- RDATA:
  - Capture `mem_r_data >> (8*off)` and truncate to `8 << size` bits.
  - Sign-extend if `req_signed`, otherwise zero-extend, into `resp_rdata`.
  - → RESP.
- RESP:
  - `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_ready`.
  - On handshake → IDLE.
- All `mem_*` outputs are registered and are 0 in every state except ISSUE. Indices, data and mask return to 0 when the strobe drops.
- All arithmetic is 64-bit unsigned; the shift amount is `8*off` and lies in 0..56.

## Timing
- Reset (any state, including mid-operation) → IDLE on the next edge.
  - Outputs after reset: `req_ready`=1; all other outputs 0.
  - A pending strobe or response is dropped and not replayed.
- Response latency for a request accepted at edge T:
  - load: `resp_valid` at T+3
  - store: at T+2
  - error: at T+1
- The bridge holds one transaction at a time. Back-to-back loads complete at best every 4 cycles; stores every 3.
- The store write takes effect at the edge ending ISSUE.
- A load issued after a store's response observes the stored data.
- `resp_valid` never drops without a handshake. `req_ready` stays 0 while a response is pending.
- `req_*` inputs are don't-care outside the accept cycle.

## Structure
- Shared package `lsu_mem_pkg` holds:
  - enum `mem_size_e` (B/H/W/D)
  - enum `bridge_state_e`
  - function `size_bytes(size)`
  - function `byte_mask_bits(size, off)`
- Sub-module `lsu_load_align`: purely combinational `(raw, off, size, signed) -> rdata`, instantiated once in RDATA.
- Everything else, including the FSM and output registers, lives in `lsu_mem_bridge`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `req_ready`=1, `resp_valid`=0, all `mem_*` outputs 0.
- Store D at `0x8000_0010`, data `0x1122334455667788`:
  - one-cycle `mem_w_enable` with index 2 and mask all ones
  - `resp_valid` at T+2 with `resp_err`=0, `resp_rdata`=0
- Store B `0xAB` at `0x8000_0013`:
  - `mem_w_data=0xAB000000`, `mem_w_mask=0xFF000000`
  - then load B signed at the same address → `0xFFFF_FFFF_FFFF_FFAB` at T+3
  - load B unsigned → `0xAB`
- Misaligned H at `0x8000_0001`, then load at `0x7FFF_FFF8`:
  - each gives `resp_err`=1 at T+1 with `resp_rdata`=0
  - no `mem_r_enable`/`mem_w_enable` pulse
- Backpressure: `resp_ready`=0 for 5 cycles after a load response appears:
  - `resp_valid`/`resp_rdata` stable and `req_ready`=0 throughout
  - exactly one handshake when `resp_ready` rises, then `req_ready`=1
- Reset during ISSUE of a store:
  - `mem_w_enable`=0 on the next cycle
  - no response is produced
  - memory read back later is unchanged.
